// File: rtl/mux2_arb_pkg.sv
// Shared types and sizing helpers for the mux2 select arbiter.
//   arb_state_t : arbiter FSM states
//   cnt_width() : counter width able to hold values 0..n-1 (minimum 1 bit)
//   SRC0/SRC1   : select values for source 0 (d0) and source 1 (d1)
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GRANT  = 2'd2
    } arb_state_t;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    localparam int unsigned DEF_SETTLE_CYCLES = 2;
    localparam int unsigned DEF_MAX_HOLD      = 8;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_SETTLE_W = cnt_width(DEF_SETTLE_CYCLES);
    localparam int unsigned DEF_HOLD_W   = cnt_width(DEF_MAX_HOLD);

endpackage

// File: rtl/mux2.sv
// Shared 2->1 data multiplexer built from XOR/AND gates.
//   d0, d1 : data sources 0 and 1
//   sel    : 0 passes d0, 1 passes d1
//   z      : selected data
module mux2 #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         sel,
    output logic [W-1:0] z
);

    logic [W-1:0] diff;

    assign diff = d0 ^ d1;
    // z = d0 when sel=0; d0^(d0^d1) = d1 when sel=1.
    assign z    = d0 ^ (diff & {W{sel}});

endmodule

// File: rtl/mux2_arbiter_rr2.sv
// Combinational round-robin pick between two requesters.
//   req    : request bits
//   ptr    : preferred source when both request
//   winner : chosen source (meaningful only when req != 0)
module arb_rr2
    import mux2_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       winner
);

    always_comb begin
        winner = SRC0;
        unique case (req)
            2'b01:   winner = SRC0;
            2'b10:   winner = SRC1;
            2'b11:   winner = ptr;
            default: winner = SRC0;
        endcase
    end

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin owner of the mux2 select line. After any select change it waits
// SETTLE_CYCLES cycles before granting so the mux path has settled, and it
// preempts an owner after MAX_HOLD grant cycles when the other side waits.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   req  : per-source request, held for the whole transfer
//   gnt  : one-hot grant, mux output valid for that source
//   sel  : drives mux2.sel
//   busy : high whenever the arbiter is not idle
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned MAX_HOLD      = DEF_MAX_HOLD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       sel,
    output logic       busy
);

    localparam int unsigned SW = cnt_width(SETTLE_CYCLES);
    localparam int unsigned HW = cnt_width(MAX_HOLD);

    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(MAX_HOLD - 1);

    arb_state_t    state;
    logic          ptr;
    logic [SW-1:0] settle_cnt;
    logic [HW-1:0] hold_cnt;
    logic          winner;

    arb_rr2 u_rr2 (
        .req    (req),
        .ptr    (ptr),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= SRC0;
            ptr        <= SRC0;
            settle_cnt <= '0;
            hold_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        if (winner == sel) begin
                            state    <= GRANT;
                            hold_cnt <= '0;
                        end else begin
                            sel        <= winner;
                            state      <= SETTLE;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                end
                SETTLE: begin
                    // Requester gave up while the mux was settling: leave sel as is.
                    if (!req[sel]) begin
                        state <= IDLE;
                    end else if (settle_cnt == '0) begin
                        state    <= GRANT;
                        hold_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                GRANT: begin
                    // Release takes priority over preemption.
                    if (!req[sel]) begin
                        state <= IDLE;
                        ptr   <= ~sel;
                    end else if (req[~sel] && (hold_cnt == HOLD_LAST)) begin
                        sel        <= ~sel;
                        ptr        <= ~sel;
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from registers only: no combinational path from req.
    assign busy = (state != IDLE);
    assign gnt  = (state == GRANT) ? (sel ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench: stimulus updates a cycle-count model and queues the
// expected outputs; a monitor pops and compares once per cycle.
module tb_mux2_arbiter;

    localparam int SETTLE = 2;
    localparam int MAXH   = 8;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       sel;
    logic       busy;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] z;

    mux2_arbiter #(
        .SETTLE_CYCLES (SETTLE),
        .MAX_HOLD      (MAXH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy)
    );

    mux2 #(
        .W (8)
    ) u_mux (
        .d0  (d0),
        .d1  (d1),
        .sel (sel),
        .z   (z)
    );

    typedef struct packed {
        logic [1:0] gnt;
        logic       sel;
        logic       busy;
        logic [7:0] z;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: which source the mux points at, whether it is granted,
    // how many settle cycles are still owed, and how many grant cycles shown.
    bit m_sel;
    bit m_pref;
    bit m_granted;
    bit m_settling;
    int m_wait;
    int m_held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_sel = 0; m_pref = 0; m_granted = 0; m_settling = 0; m_wait = 0; m_held = 0;
    endtask

    task automatic switch_to(input bit s);
        m_sel      = s;
        m_granted  = 0;
        m_settling = 1;
        m_wait     = SETTLE;
    endtask

    // Apply one clock edge given the inputs that edge samples.
    task automatic model_edge(input logic [1:0] r, input logic rs);
        bit want;
        if (rs) begin
            model_reset();
        end else if (m_granted) begin
            if (!r[m_sel]) begin
                m_granted = 0;
                m_pref    = !m_sel;
            end else if (r[!m_sel] && m_held >= MAXH) begin
                m_pref = !m_sel;
                switch_to(!m_sel);
            end
        end else if (m_settling) begin
            if (!r[m_sel]) begin
                m_settling = 0;
            end else if (m_wait == 0) begin
                m_settling = 0;
                m_granted  = 1;
                m_held     = 0;
            end
        end else if (r != 2'b00) begin
            want = (r == 2'b11) ? m_pref : r[1];
            if (want == m_sel) begin
                m_granted = 1;
                m_held    = 0;
            end else begin
                switch_to(want);
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One cycle: model the edge, then drive the inputs for the following edge.
    task automatic step(input logic [1:0] r, input logic rs);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge(req, rst);
        req = r;
        rst = rs;
        d0  = 8'($urandom);
        d1  = 8'($urandom);
        e.gnt  = m_granted ? (m_sel ? 2'b10 : 2'b01) : 2'b00;
        e.sel  = m_sel;
        e.busy = m_granted || m_settling;
        e.z    = m_sel ? d1 : d0;
        sb_q.push_back(e);
        if (m_granted) m_held++;
        if (m_settling) m_wait--;
    endtask

    task automatic run(input logic [1:0] r, input int n);
        for (int i = 0; i < n; i++) step(r, 1'b0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("gnt", {6'b0, gnt}, {6'b0, e.gnt});
                check("sel", {7'b0, sel}, {7'b0, e.sel});
                check("busy", {7'b0, busy}, {7'b0, e.busy});
                if (e.gnt != 2'b00) check("mux_z", z, e.z);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t expected below 1000000",
                 $time);
        $fatal(1);
    end

    initial begin
        logic [1:0] r;
        logic       rs;
        model_reset();
        rst = 1'b1;
        req = 2'b00;
        d0  = 8'h00;
        d1  = 8'h00;

        // Reset, then source 0 alone: immediate grant.
        step(2'b00, 1'b1);
        step(2'b01, 1'b0);
        run(2'b01, 4);
        run(2'b00, 2);

        // Source 1 from sel=0: settle then grant.
        step(2'b00, 1'b1);
        step(2'b10, 1'b0);
        run(2'b10, 6);
        run(2'b00, 2);

        // Both requesting: alternating preemption.
        step(2'b00, 1'b1);
        step(2'b11, 1'b0);
        run(2'b11, 45);
        run(2'b00, 2);

        // Abort during settle.
        step(2'b00, 1'b1);
        step(2'b10, 1'b0);
        run(2'b00, 3);

        // Reset mid-grant, then re-arbitrate.
        step(2'b00, 1'b1);
        step(2'b01, 1'b0);
        run(2'b01, 3);
        step(2'b01, 1'b1);
        run(2'b01, 3);
        run(2'b00, 2);

        // Uncontended long hold, release, then contention resolved by pointer.
        step(2'b01, 1'b0);
        run(2'b01, 20);
        run(2'b00, 2);
        run(2'b11, 6);
        run(2'b00, 2);

        // Random traffic with sticky requests and rare resets.
        r = 2'b00;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) r[0] = ~r[0];
            if ($urandom_range(0, 7) == 0) r[1] = ~r[1];
            rs = ($urandom_range(0, 99) == 0);
            step(r, rs);
        end

        repeat (2) @(posedge clk);
        #3;
        check("queue_drained", 8'(sb_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
